// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and constants for the TDM frame collector
//
// Purpose: slot geometry of the 4-slot serial stream, collector FSM state
// encoding and the FIFO entry layout used by tdm_frame_collector.
// Ports: none (package).

package tdm_pkg;

  localparam int SLOTS  = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // One buffered frame: data bit n was sampled in slot n.
  typedef struct packed {
    logic             changed;
    logic [SLOTS-1:0] data;
  } frame_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - parameterised synchronous FIFO with occupancy counter
//
// Purpose: small register-based FIFO; head is shown combinationally from
// storage and forced to zero while empty.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, push_data  write request and data
//   pop              read request (ignored while empty)
//   full, empty      occupancy flags
//   head             oldest entry, zero while empty

module sync_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    // A push into a full FIFO is still accepted when a pop frees the slot.
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/tdm_frame_collector.sv
// rtl/tdm_frame_collector.sv - reassembles 4-slot TDM sweeps into buffered frames
//
// Purpose: samples ser_in per slot, checks the slot sequence, pushes each
// completed 4-bit frame (with a changed-vs-previous flag) into a FIFO read
// out with a valid/ready handshake.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ser_in, slot          serial bit and its slot index
//   out_ready             consumer takes head frame
//   out_valid, out_data   head frame presented
//   out_changed           head frame differs from the frame accepted before it
//   sync_err, overflow    one-cycle pulses: sequence error / frame dropped
//   frame_count           accepted frames (wraps)
//   drop_count            dropped frames (saturates)

module tdm_frame_collector
  import tdm_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic [1:0]       slot,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [3:0]       out_data,
  output logic             out_changed,
  output logic             sync_err,
  output logic             overflow,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

  state_e                state_q, state_d;
  logic [SLOT_W-1:0]     exp_q, exp_d;
  // Bits 0..2 of the frame in progress; bit 3 is taken straight from ser_in.
  logic [SLOTS-2:0]      shift_q, shift_d;
  logic                  sync_err_q, sync_err_d;
  logic                  overflow_q, overflow_d;
  logic [SLOTS-1:0]      last_frame_q, last_frame_d;
  logic                  have_last_q, have_last_d;
  logic [CNT_W-1:0]      frame_count_q, frame_count_d;
  logic [CNT_W-1:0]      drop_count_q, drop_count_d;

  logic                  frame_done;
  logic [SLOTS-1:0]      frame_data;
  logic                  push;
  logic                  pop;
  frame_t                push_entry;
  frame_t                fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      exp_q         <= '0;
      shift_q       <= '0;
      sync_err_q    <= 1'b0;
      overflow_q    <= 1'b0;
      last_frame_q  <= '0;
      have_last_q   <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      exp_q         <= exp_d;
      shift_q       <= shift_d;
      sync_err_q    <= sync_err_d;
      overflow_q    <= overflow_d;
      last_frame_q  <= last_frame_d;
      have_last_q   <= have_last_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

  // Next-state logic: slot sequencing and frame assembly
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    shift_d    = shift_q;
    sync_err_d = 1'b0;
    frame_done = 1'b0;
    frame_data = {ser_in, shift_q};
    case (state_q)
      HUNT: begin
        if (slot == '0) begin
          shift_d = {{(SLOTS-2){1'b0}}, ser_in};
          exp_d   = SLOT_W'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (slot == exp_q) begin
          if (slot == LAST_SLOT) begin
            // Clearing here means slot 0 of the next sweep starts clean.
            frame_done = 1'b1;
            exp_d      = '0;
            shift_d    = '0;
          end else begin
            shift_d[slot] = ser_in;
            exp_d         = exp_q + SLOT_W'(1);
          end
        end else begin
          sync_err_d = 1'b1;
          if (slot == '0) begin
            // An early slot 0 is treated as the start of a fresh sweep.
            shift_d = {{(SLOTS-2){1'b0}}, ser_in};
            exp_d   = SLOT_W'(1);
          end else begin
            shift_d = '0;
            exp_d   = '0;
            state_d = HUNT;
          end
        end
      end
      default: begin
        state_d = HUNT;
        exp_d   = '0;
        shift_d = '0;
      end
    endcase
  end

  // Output / datapath logic: FIFO push, change tracking, counters
  always_comb begin
    pop                = ~fifo_empty & out_ready;
    push               = frame_done & (~fifo_full | pop);
    push_entry.data    = frame_data;
    push_entry.changed = have_last_q & (frame_data != last_frame_q);
    last_frame_d       = last_frame_q;
    have_last_d        = have_last_q;
    frame_count_d      = frame_count_q;
    drop_count_d       = drop_count_q;
    overflow_d         = frame_done & ~push;
    if (push) begin
      last_frame_d  = frame_data;
      have_last_d   = 1'b1;
      frame_count_d = frame_count_q + CNT_W'(1);
    end
    if (overflow_d && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + CNT_W'(1);
    end
  end

  sync_fifo #(
    .WIDTH ($bits(frame_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign out_valid   = ~fifo_empty;
  assign out_data    = fifo_head.data;
  assign out_changed = fifo_head.changed;
  assign sync_err    = sync_err_q;
  assign overflow    = overflow_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_tdm_frame_collector.sv
// tb/tb_tdm_frame_collector.sv - directed self-checking bench for tdm_frame_collector

module tb_tdm_frame_collector;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ser_in;
  logic [1:0]       slot;
  logic             out_ready;
  logic             out_valid;
  logic [3:0]       out_data;
  logic             out_changed;
  logic             sync_err;
  logic             overflow;
  logic [CNT_W-1:0] frame_count;
  logic [CNT_W-1:0] drop_count;

  int errors   = 0;
  int checks   = 0;
  int sync_cnt = 0;
  int ovf_cnt  = 0;

  logic [3:0] frames [6];

  tdm_frame_collector #(
    .FIFO_DEPTH (4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ser_in      (ser_in),
    .slot        (slot),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_changed (out_changed),
    .sync_err    (sync_err),
    .overflow    (overflow),
    .frame_count (frame_count),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one slot, clock it, then sample 1 time unit after the edge.
  task automatic cyc(input logic [1:0] s, input logic b, input logic r);
    slot      = s;
    ser_in    = b;
    out_ready = r;
    @(posedge clk);
    #1;
    if (sync_err) sync_cnt++;
    if (overflow) ovf_cnt++;
  endtask

  task automatic sweep(input logic [3:0] f, input logic r, input logic r_last);
    for (int n = 0; n < 4; n++) begin
      cyc(2'(n), f[n], (n == 3) ? r_last : r);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    slot      = 2'd0;
    ser_in    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    sync_cnt = 0;
    ovf_cnt  = 0;
  endtask

  initial begin
    frames[0] = 4'h1; frames[1] = 4'h2; frames[2] = 4'h3;
    frames[3] = 4'h4; frames[4] = 4'h5; frames[5] = 4'h6;

    // Reset values
    rst_n = 1'b0; slot = 2'd0; ser_in = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",   out_valid,   0);
    check("rst_data",    out_data,    0);
    check("rst_changed", out_changed, 0);
    check("rst_syncerr", sync_err,    0);
    check("rst_ovf",     overflow,    0);
    check("rst_fcnt",    frame_count, 0);
    check("rst_dcnt",    drop_count,  0);

    // First sweep 1,0,1,1 -> 1101
    do_reset();
    cyc(2'd0, 1'b1, 1'b0);
    cyc(2'd1, 1'b0, 1'b0);
    cyc(2'd2, 1'b1, 1'b0);
    check("t1_valid_early", out_valid, 0);
    cyc(2'd3, 1'b1, 1'b0);
    check("t1_valid",   out_valid,   1);
    check("t1_data",    out_data,    4'b1101);
    check("t1_changed", out_changed, 0);
    check("t1_fcnt",    frame_count, 1);

    // 1101, 1101, 0110 with out_ready=1 -> changed 0,0,1
    do_reset();
    sweep(4'b1101, 1'b1, 1'b1);
    check("t2_data0",    out_data,    4'b1101);
    check("t2_changed0", out_changed, 0);
    sweep(4'b1101, 1'b1, 1'b1);
    check("t2_data1",    out_data,    4'b1101);
    check("t2_changed1", out_changed, 0);
    sweep(4'b0110, 1'b1, 1'b1);
    check("t2_data2",    out_data,    4'b0110);
    check("t2_changed2", out_changed, 1);
    check("t2_fcnt",     frame_count, 3);
    check("t2_nosync",   sync_cnt,    0);

    // Slot sequence 0,1,3 -> one sync_err, no frame; then 1111
    cyc(2'd0, 1'b0, 1'b1);
    cyc(2'd1, 1'b0, 1'b1);
    cyc(2'd3, 1'b0, 1'b1);
    check("t3_syncerr", sync_err,    1);
    check("t3_valid",   out_valid,   0);
    check("t3_fcnt",    frame_count, 3);
    sweep(4'b1111, 1'b0, 1'b0);
    check("t3_data",    out_data,    4'b1111);
    check("t3_changed", out_changed, 1);
    check("t3_fcnt2",   frame_count, 4);
    check("t3_synccnt", sync_cnt,    1);

    // Six sweeps into a depth-4 FIFO with out_ready=0
    do_reset();
    for (int i = 0; i < 6; i++) sweep(frames[i], 1'b0, 1'b0);
    check("t4_ovfcnt", ovf_cnt,     2);
    check("t4_dcnt",   drop_count,  2);
    check("t4_fcnt",   frame_count, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_valid%0d", i),   out_valid,   1);
      check($sformatf("t4_data%0d", i),    out_data,    32'(frames[i]));
      check($sformatf("t4_changed%0d", i), out_changed, (i == 0) ? 0 : 1);
      cyc(2'd2, 1'b0, 1'b1);
    end
    check("t4_empty", out_valid, 0);
    // Last accepted frame was 0100; dropped frames must not have replaced it.
    sweep(4'h4, 1'b0, 1'b0);
    check("t4_relast_data",    out_data,    4'h4);
    check("t4_relast_changed", out_changed, 0);
    check("t4_fcnt2",          frame_count, 5);

    // Full FIFO with a pop on the completing edge
    do_reset();
    for (int i = 0; i < 4; i++) sweep(frames[i], 1'b0, 1'b0);
    sweep(frames[4], 1'b0, 1'b1);
    check("t5_ovfcnt", ovf_cnt,     0);
    check("t5_dcnt",   drop_count,  0);
    check("t5_fcnt",   frame_count, 5);
    for (int i = 1; i < 5; i++) begin
      check($sformatf("t5_valid%0d", i), out_valid, 1);
      check($sformatf("t5_data%0d", i),  out_data,  32'(frames[i]));
      cyc(2'd2, 1'b0, 1'b1);
    end
    check("t5_empty", out_valid, 0);

    // Reset mid-frame with two frames queued
    do_reset();
    sweep(frames[0], 1'b0, 1'b0);
    sweep(frames[1], 1'b0, 1'b0);
    cyc(2'd0, 1'b1, 1'b0);
    cyc(2'd1, 1'b1, 1'b0);
    cyc(2'd2, 1'b1, 1'b0);
    check("t6_pre_valid", out_valid,   1);
    check("t6_pre_fcnt",  frame_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid,   0);
    check("t6_rst_data",  out_data,    0);
    check("t6_rst_fcnt",  frame_count, 0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    sync_cnt = 0;
    cyc(2'd3, 1'b1, 1'b0);
    check("t6_slot3_valid", out_valid, 0);
    cyc(2'd0, 1'b0, 1'b0);
    cyc(2'd1, 1'b1, 1'b0);
    cyc(2'd2, 1'b0, 1'b0);
    check("t6_partial_valid", out_valid, 0);
    cyc(2'd3, 1'b1, 1'b0);
    check("t6_valid",   out_valid,   1);
    check("t6_data",    out_data,    4'b1010);
    check("t6_changed", out_changed, 0);
    check("t6_fcnt",    frame_count, 1);
    check("t6_nosync",  sync_cnt,    0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
